// File: rtl/agc_level_monitor.sv
// Windowed mean-square level monitor with debounced lock status for the AGC output.
// Optional running peak magnitude is compiled in when AGC_MON_PEAK_EN is defined.
module agc_level_monitor #(
   parameter int WIN_LOG2   = 8,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               restart,
   input  logic               x_valid,
   input  logic signed [15:0] x_in,
   input  logic        [15:0] reference,
   input  logic        [15:0] tol,
   output logic        [31:0] ms_out,
   output logic               ms_valid,
   output logic               in_band,
   output logic               locked,
   output logic        [15:0] peak_out
);

   localparam int ACC_W = 32 + WIN_LOG2;
   localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);
   localparam logic [3:0]          LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0]          UNLOCK_N = 4'(UNLOCK_CNT);

   typedef enum logic {SEARCH, LOCKED} state_t;

   function automatic logic [32:0] mag33(input logic signed [32:0] v);
      logic signed [32:0] n;
      n = -v;
      return v[32] ? n : v;
   endfunction

   logic [WIN_LOG2-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [31:0]         ms_q, ms_d;
   logic                vld_q, vld_d;
   logic                inb_q, inb_d;
   logic [3:0]          dcnt_q, dcnt_d;
   state_t              state_q, state_d;

   logic signed [31:0] prod;
   logic [31:0]        sq;
   logic               accept;
   logic               close;
   logic [ACC_W-1:0]   acc_sum;
   logic [31:0]        ms_new;
   logic [14:0]        ref_half;
   logic [29:0]        ref_sq;
   logic [31:0]        ref_ms;
   logic signed [32:0] diff;
   logic [32:0]        err;
   logic               inb_new;
   logic [3:0]         dcnt_inc;
   logic [8:0]         unused_bits;

   // Square, accumulate and compare the closing window against the target level
   always_comb begin
      prod     = x_in * x_in;
      sq       = prod;
      accept   = x_valid & ~restart;
      close    = accept & (cnt_q == '1);
      acc_sum  = acc_q + {{WIN_LOG2{1'b0}}, sq};
      ms_new   = acc_sum[WIN_LOG2 +: 32];
      ref_half = reference[15:1];
      ref_sq   = ref_half * ref_half;
      ref_ms   = {2'b00, ref_sq};
      diff     = $signed({1'b0, ms_new}) - $signed({1'b0, ref_ms});
      err      = mag33(diff);
      inb_new  = err[32:8] <= {9'b0, tol};
      dcnt_inc = dcnt_q + 4'd1;
   end

   assign unused_bits = {reference[0], err[7:0]};

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      ms_d    = ms_q;
      vld_d   = 1'b0;
      inb_d   = inb_q;
      dcnt_d  = dcnt_q;
      state_d = state_q;
      if (restart) begin
         cnt_d   = '0;
         acc_d   = '0;
         dcnt_d  = 4'd0;
         inb_d   = 1'b0;
         state_d = SEARCH;
      end else if (accept) begin
         cnt_d = cnt_q + CNT_ONE;
         acc_d = acc_sum;
         if (close) begin
            acc_d = '0;
            ms_d  = ms_new;
            vld_d = 1'b1;
            inb_d = inb_new;
            // Debounce counts consecutive windows that disagree with the current status
            case (state_q)
               SEARCH: begin
                  if (!inb_new) begin
                     dcnt_d = 4'd0;
                  end else if (dcnt_inc == LOCK_N) begin
                     dcnt_d  = 4'd0;
                     state_d = LOCKED;
                  end else begin
                     dcnt_d = dcnt_inc;
                  end
               end
               LOCKED: begin
                  if (inb_new) begin
                     dcnt_d = 4'd0;
                  end else if (dcnt_inc == UNLOCK_N) begin
                     dcnt_d  = 4'd0;
                     state_d = SEARCH;
                  end else begin
                     dcnt_d = dcnt_inc;
                  end
               end
               default: begin
                  dcnt_d  = 4'd0;
                  state_d = SEARCH;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         ms_q    <= 32'd0;
         vld_q   <= 1'b0;
         inb_q   <= 1'b0;
         dcnt_q  <= 4'd0;
         state_q <= SEARCH;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         ms_q    <= ms_d;
         vld_q   <= vld_d;
         inb_q   <= inb_d;
         dcnt_q  <= dcnt_d;
         state_q <= state_d;
      end
   end

   assign ms_out   = ms_q;
   assign ms_valid = vld_q;
   assign in_band  = inb_q;
   assign locked   = (state_q == LOCKED);

`ifdef AGC_MON_PEAK_EN
   function automatic logic [15:0] abs_sat16(input logic signed [15:0] v);
      logic signed [15:0] n;
      n = -v;
      if (v == 16'sh8000) return 16'h7FFF;
      return v[15] ? n : v;
   endfunction

   logic [15:0] prun_q, prun_d;
   logic [15:0] peak_q, peak_d;
   logic [15:0] amag;
   logic [15:0] pmax;

   always_comb begin
      amag   = abs_sat16(x_in);
      pmax   = (amag > prun_q) ? amag : prun_q;
      prun_d = prun_q;
      peak_d = peak_q;
      if (restart) begin
         prun_d = 16'd0;
      end else if (accept) begin
         prun_d = pmax;
         if (close) begin
            peak_d = pmax;
            prun_d = 16'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prun_q <= 16'd0;
         peak_q <= 16'd0;
      end else begin
         prun_q <= prun_d;
         peak_q <= peak_d;
      end
   end

   assign peak_out = peak_q;
`else
   assign peak_out = 16'd0;
`endif

endmodule

// File: tb/tb_agc_level_monitor.sv
// Self-checking bench for agc_level_monitor: directed test-plan steps plus random
// windows, all compared each cycle against a window-sum reference model.
module tb_agc_level_monitor;

   localparam int WIN = 256;
   localparam int LCK = 4;
   localparam int ULK = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               restart = 1'b0;
   logic               x_valid = 1'b0;
   logic signed [15:0] x_in = 16'sd0;
   logic        [15:0] reference = 16'd0;
   logic        [15:0] tol = 16'd0;
   logic        [31:0] ms_out;
   logic               ms_valid;
   logic               in_band;
   logic               locked;
   logic        [15:0] peak_out;

   int checks = 0;
   int errors = 0;

   // reference model state
   longint win_sum;
   int     win_n;
   int     run_peak;
   int     streak;
   logic [31:0] e_ms;
   logic        e_vld;
   logic        e_inb;
   logic        e_lock;
   logic [15:0] e_peak;

   agc_level_monitor #(.WIN_LOG2(8), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK)) dut (
      .clk(clk), .rst(rst), .restart(restart), .x_valid(x_valid), .x_in(x_in),
      .reference(reference), .tol(tol), .ms_out(ms_out), .ms_valid(ms_valid),
      .in_band(in_band), .locked(locked), .peak_out(peak_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      win_sum = 0; win_n = 0; run_peak = 0; streak = 0;
      e_ms = 0; e_vld = 0; e_inb = 0; e_lock = 0; e_peak = 0;
   endtask

   task automatic model_clock();
      int     xs, am, r;
      longint ms, rms, err;
      e_vld = 1'b0;
      if (!rst) begin
         model_reset();
      end else if (restart) begin
         win_sum = 0; win_n = 0; run_peak = 0; streak = 0;
         e_inb = 0; e_lock = 0;
      end else if (x_valid) begin
         xs = x_in;
         am = (xs < 0) ? -xs : xs;
         if (am > 32767) am = 32767;
         if (am > run_peak) run_peak = am;
         win_sum += longint'(xs) * xs;
         win_n++;
         if (win_n == WIN) begin
            ms  = win_sum / WIN;
            r   = reference / 2;
            rms = longint'(r) * r;
            err = (ms > rms) ? ms - rms : rms - ms;
            e_ms  = ms[31:0];
            e_vld = 1'b1;
            e_inb = (err / 256) <= tol;
            // streak counts windows disagreeing with the status since it last changed
            if (e_inb != e_lock) streak++; else streak = 0;
            if (!e_lock && streak == LCK) begin e_lock = 1; streak = 0; end
            else if (e_lock && streak == ULK) begin e_lock = 0; streak = 0; end
`ifdef AGC_MON_PEAK_EN
            e_peak = 16'(run_peak);
`endif
            run_peak = 0; win_sum = 0; win_n = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("ms_out", ms_out, e_ms);
      chk("ms_valid", {31'd0, ms_valid}, {31'd0, e_vld});
      chk("in_band", {31'd0, in_band}, {31'd0, e_inb});
      chk("locked", {31'd0, locked}, {31'd0, e_lock});
      chk("peak_out", {16'd0, peak_out}, {16'd0, e_peak});
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      check_all();
   endtask

   task automatic run(input int n, input logic signed [15:0] x);
      x_valid = 1'b1; x_in = x;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int acc_n;
      model_reset();
      #13;
      check_all();
      chk("reset_locked", {31'd0, locked}, 32'd0);
      rst = 1'b1;

      // constant lock
      reference = 16'd32768; tol = 16'd0;
      run(1023, 16'sd16384);
      chk("pre_lock", {31'd0, locked}, 32'd0);
      run(1, 16'sd16384);
      chk("lock_4th", {31'd0, locked}, 32'd1);
      chk("lock_ms", ms_out, 32'h1000_0000);
      chk("lock_inb", {31'd0, in_band}, 32'd1);
      run(256, 16'sd16384);

      // unlock debounce
      run(256, 16'sd0);
      chk("unl_1st_inb", {31'd0, in_band}, 32'd0);
      chk("unl_1st_lock", {31'd0, locked}, 32'd1);
      run(256, 16'sd0);
      chk("unl_2nd_lock", {31'd0, locked}, 32'd0);

      // tolerance edge
      tol = 16'd128;
      run(256, 16'sd16385);
      chk("tol128_inb", {31'd0, in_band}, 32'd1);
      chk("tol128_ms", ms_out, 32'h1000_8001);
      tol = 16'd127;
      run(256, 16'sd16385);
      chk("tol127_inb", {31'd0, in_band}, 32'd0);

      // gapped input and restart
      tol = 16'd0; x_in = 16'sd16384;
      restart = 1'b1; x_valid = 1'b1; step(); restart = 1'b0;
      acc_n = 0;
      for (int c = 0; c < 4000 && acc_n < WIN; c++) begin
         x_valid = 1'($urandom_range(1));
         step();
         if (x_valid) acc_n++;
      end
      chk("gap_strobe", {31'd0, ms_valid}, 32'd1);
      acc_n = 0;
      for (int c = 0; c < 4000 && acc_n < 100; c++) begin
         x_valid = 1'($urandom_range(1));
         step();
         if (x_valid) acc_n++;
      end
      restart = 1'b1; x_valid = 1'b1; x_in = 16'sd32767; step(); restart = 1'b0;
      chk("rst_locked", {31'd0, locked}, 32'd0);
      x_in = 16'sd16384;
      acc_n = 0;
      for (int c = 0; c < 4000 && acc_n < WIN; c++) begin
         x_valid = 1'($urandom_range(1));
         step();
         if (x_valid) acc_n++;
      end
      chk("restart_strobe", {31'd0, ms_valid}, 32'd1);
      chk("restart_ms", ms_out, 32'h1000_0000);

      // full scale
      run(256, -16'sd32768);
      chk("fs_ms", ms_out, 32'h4000_0000);
`ifdef AGC_MON_PEAK_EN
      chk("fs_peak", {16'd0, peak_out}, 32'd32767);
`endif

      // random windows
      restart = 1'b1; step(); restart = 1'b0;
      for (int c = 0; c < 1200; c++) begin
         if (c % 300 == 0) begin
            reference = 16'($urandom);
            tol = 16'($urandom_range(65535));
         end
         x_valid = 1'($urandom_range(3) != 0);
         x_in = 16'($urandom);
         step();
      end

      // async reset while locked
      restart = 1'b1; step(); restart = 1'b0;
      reference = 16'd32768; tol = 16'd0;
      run(1024, 16'sd16384);
      chk("pre_arst_lock", {31'd0, locked}, 32'd1);
      run(100, 16'sd16384);
      #1 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("arst_ms", ms_out, 32'd0);
      chk("arst_lock", {31'd0, locked}, 32'd0);
      step();
      step();
      rst = 1'b1;
      run(255, 16'sd16384);
      chk("post_arst_nostrobe", {31'd0, ms_valid}, 32'd0);
      run(1, 16'sd16384);
      chk("post_arst_strobe", {31'd0, ms_valid}, 32'd1);
      x_valid = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
